// File: rtl/signext_pipe.sv
// Pipelined lane resizer (zero/sign extend, signed/unsigned saturating narrow)
// with a 2-entry skid buffer on a valid/ready stream and a saturation counter.
module signext_pipe #(
    parameter int N  = 3,
    parameter int M  = 5,
    parameter int L  = 1,
    parameter int CW = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    output logic           o_in_ready,
    input  logic [L*N-1:0] i_data,
    input  logic [1:0]     i_mode,
    output logic           o_valid,
    input  logic           i_out_ready,
    output logic [L*M-1:0] o_data,
    output logic [L-1:0]   o_sat,
    input  logic           i_sat_clr,
    output logic [CW-1:0]  o_sat_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    // Returns {sat, resized} for one lane; indices are clamped so every
    // parameter combination elaborates without out-of-range selects.
    function automatic logic [M:0] resize_lane(input logic [N-1:0] x, input logic [1:0] mode);
        logic [M-1:0] r;
        logic         sat;
        logic         ovf;
        r   = {M{1'b0}};
        sat = 1'b0;
        ovf = 1'b0;
        if (M >= N) begin
            for (int i = 0; i < M; i++) begin
                if (i < N) begin
                    r[i] = x[(i < N) ? i : N-1];
                end else begin
                    r[i] = (mode == 2'b01 || mode == 2'b10) ? x[N-1] : 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < M; i++) begin
                r[i] = x[(i < N) ? i : N-1];
            end
            case (mode)
                2'b10: begin
                    // Fits iff bits M-1..N-1 all equal the sign bit.
                    for (int i = M-1; i < N; i++) begin
                        if (x[i] != x[N-1]) begin
                            ovf = 1'b1;
                        end else begin
                            ovf = ovf;
                        end
                    end
                    if (ovf) begin
                        sat = 1'b1;
                        for (int i = 0; i < M; i++) begin
                            r[i] = (i == M-1) ? x[N-1] : ~x[N-1];
                        end
                    end else begin
                        sat = 1'b0;
                    end
                end
                2'b11: begin
                    for (int i = M; i < N; i++) begin
                        ovf = ovf | x[i];
                    end
                    if (ovf) begin
                        sat = 1'b1;
                        r   = {M{1'b1}};
                    end else begin
                        sat = 1'b0;
                    end
                end
                default: begin
                    sat = 1'b0;
                end
            endcase
        end
        return {sat, r};
    endfunction

    state_t         state_q, state_d;
    logic           valid_q, valid_d;
    logic           in_ready_q, in_ready_d;
    logic [L*M-1:0] out_data_q, out_data_d;
    logic [L-1:0]   out_sat_q, out_sat_d;
    logic [L*M-1:0] skid_data_q, skid_data_d;
    logic [L-1:0]   skid_sat_q, skid_sat_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [L*M-1:0] rs_data_s;
    logic [L-1:0]   rs_sat_s;
    logic           in_xfer_s;
    logic           out_xfer_s;

    // Resize every lane of the incoming beat ahead of the output register.
    always_comb begin
        logic [M:0] lane_v;
        lane_v    = {(M+1){1'b0}};
        rs_data_s = {(L*M){1'b0}};
        rs_sat_s  = {L{1'b0}};
        for (int k = 0; k < L; k++) begin
            lane_v                = resize_lane(i_data[k*N +: N], i_mode);
            rs_data_s[k*M +: M]   = lane_v[M-1:0];
            rs_sat_s[k]           = lane_v[M];
        end
    end

    // Buffer next-state, data steering and saturation counter.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        skid_data_d = skid_data_q;
        skid_sat_d  = skid_sat_q;
        in_xfer_s   = i_valid & in_ready_q;
        out_xfer_s  = valid_q & i_out_ready;

        case (state_q)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    state_d    = ST_ONE;
                    out_data_d = rs_data_s;
                    out_sat_d  = rs_sat_s;
                end else begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    out_data_d = rs_data_s;
                    out_sat_d  = rs_sat_s;
                end else if (in_xfer_s) begin
                    state_d     = ST_FULL;
                    skid_data_d = rs_data_s;
                    skid_sat_d  = rs_sat_s;
                end else if (out_xfer_s) begin
                    state_d     = ST_EMPTY;
                end else begin
                    state_d     = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_xfer_s) begin
                    state_d    = ST_ONE;
                    out_data_d = skid_data_q;
                    out_sat_d  = skid_sat_q;
                end else begin
                    state_d    = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        valid_d    = (state_d != ST_EMPTY);
        in_ready_d = (state_d != ST_FULL);

        if (i_sat_clr) begin
            cnt_d = {CW{1'b0}};
        end else if (in_xfer_s && (|rs_sat_s) && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_EMPTY;
            valid_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_data_q  <= {(L*M){1'b0}};
            out_sat_q   <= {L{1'b0}};
            skid_data_q <= {(L*M){1'b0}};
            skid_sat_q  <= {L{1'b0}};
            cnt_q       <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            skid_data_q <= skid_data_d;
            skid_sat_q  <= skid_sat_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_in_ready = in_ready_q;
    assign o_valid    = valid_q;
    assign o_data     = out_data_q;
    assign o_sat      = out_sat_q;
    assign o_sat_cnt  = cnt_q;

endmodule

// File: tb/tb_signext_pipe.sv
// Bench for signext_pipe: two instances (widen N=3/M=5/L=1, narrow N=5/M=3/L=4/CW=2)
// checked against an arithmetic reference model and an ordered scoreboard.
module tb_signext_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        v0, ir0, ov0, or0, clr0;
    logic [2:0]  d0;
    logic [1:0]  m0;
    logic [4:0]  od0;
    logic [0:0]  os0;
    logic [15:0] cnt0;

    logic        v1, ir1, ov1, or1, clr1;
    logic [19:0] d1;
    logic [1:0]  m1;
    logic [11:0] od1;
    logic [3:0]  os1;
    logic [1:0]  cnt1;

    signext_pipe #(.N(3), .M(5), .L(1), .CW(16)) u0 (
        .i_clk(clk), .i_rst(rst), .i_valid(v0), .o_in_ready(ir0), .i_data(d0), .i_mode(m0),
        .o_valid(ov0), .i_out_ready(or0), .o_data(od0), .o_sat(os0), .i_sat_clr(clr0),
        .o_sat_cnt(cnt0));

    signext_pipe #(.N(5), .M(3), .L(4), .CW(2)) u1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_in_ready(ir1), .i_data(d1), .i_mode(m1),
        .o_valid(ov1), .i_out_ready(or1), .o_data(od1), .o_sat(os1), .i_sat_clr(clr1),
        .o_sat_cnt(cnt1));

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] q0_d[$], q0_s[$], q1_d[$], q1_s[$];
    int c0 = 0, c1 = 0;
    bit er0 = 1'b0, er1 = 1'b0;

    // Resize one lane using integer arithmetic on its numeric value.
    function automatic void model_lane(input int n, input int m, input int x, input int mode,
                                       output int y, output bit s);
        int sx, lo, hi, p;
        p  = 1 << m;
        s  = 1'b0;
        sx = (x >= (1 << (n-1))) ? x - (1 << n) : x;
        if (m >= n) begin
            y = (mode == 1 || mode == 2) ? (sx + p) % p : x;
        end else begin
            case (mode)
                2: begin
                    lo = -(p/2);
                    hi = p/2 - 1;
                    if (sx < lo) begin y = lo + p; s = 1'b1; end
                    else if (sx > hi) begin y = hi; s = 1'b1; end
                    else y = (sx + p) % p;
                end
                3: begin
                    if (x > p - 1) begin y = p - 1; s = 1'b1; end
                    else y = x;
                end
                default: y = x % p;
            endcase
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, then advance the model across the next edge.
    task automatic tick();
        int y;
        bit s;
        logic [63:0] ed, es;
        chk("rdy0", 64'(ir0), 64'(er0));
        chk("valid0", 64'(ov0), 64'(q0_d.size() != 0));
        if (q0_d.size() != 0) begin
            chk("data0", 64'(od0), q0_d[0]);
            chk("sat0", 64'(os0), q0_s[0]);
        end
        chk("cnt0", 64'(cnt0), 64'(c0));
        chk("rdy1", 64'(ir1), 64'(er1));
        chk("valid1", 64'(ov1), 64'(q1_d.size() != 0));
        if (q1_d.size() != 0) begin
            chk("data1", 64'(od1), q1_d[0]);
            chk("sat1", 64'(os1), q1_s[0]);
        end
        chk("cnt1", 64'(cnt1), 64'(c1));

        if (rst) begin
            q0_d.delete(); q0_s.delete(); q1_d.delete(); q1_s.delete();
            c0 = 0; c1 = 0; er0 = 1'b0; er1 = 1'b0;
        end else begin
            if (q0_d.size() != 0 && or0) begin void'(q0_d.pop_front()); void'(q0_s.pop_front()); end
            if (v0 && er0) begin
                model_lane(3, 5, int'(d0), int'(m0), y, s);
                q0_d.push_back(64'(y));
                q0_s.push_back(64'(s));
                if (s && c0 < 65535) c0++;
            end
            if (clr0) c0 = 0;
            er0 = (q0_d.size() < 2);

            if (q1_d.size() != 0 && or1) begin void'(q1_d.pop_front()); void'(q1_s.pop_front()); end
            if (v1 && er1) begin
                ed = 64'd0;
                es = 64'd0;
                for (int k = 0; k < 4; k++) begin
                    model_lane(5, 3, int'(d1[k*5 +: 5]), int'(m1), y, s);
                    ed = ed | (64'(y) << (k*3));
                    es[k] = s;
                end
                q1_d.push_back(ed);
                q1_s.push_back(es);
                if (es != 64'd0 && c1 < 3) c1++;
            end
            if (clr1) c1 = 0;
            er1 = (q1_d.size() < 2);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        logic [11:0] hold;
        rst = 1'b1;
        v0 = 1'b0; or0 = 1'b0; clr0 = 1'b0; d0 = 3'd0; m0 = 2'd0;
        v1 = 1'b0; or1 = 1'b0; clr1 = 1'b0; d1 = 20'd0; m1 = 2'd0;
        @(posedge clk);
        #1;
        tick();
        chk("rst_data0", 64'(od0), 64'd0);
        chk("rst_sat1", 64'(os1), 64'd0);
        rst = 1'b0;
        tick();
        tick();

        // Widening: sign and zero extension with latency 1.
        or0 = 1'b1;
        m0 = 2'b01; d0 = 3'b100; v0 = 1'b1; tick(); v0 = 1'b0;
        chk("se100", 64'(od0), 64'(5'b11100));
        chk("se100_sat", 64'(os0), 64'd0);
        tick();
        d0 = 3'b011; v0 = 1'b1; tick(); v0 = 1'b0;
        chk("se011", 64'(od0), 64'(5'b00011));
        tick();
        m0 = 2'b00; d0 = 3'b100; v0 = 1'b1; tick(); v0 = 1'b0;
        chk("ze100", 64'(od0), 64'(5'b00100));
        tick();
        m0 = 2'b11; v0 = 1'b1; tick(); v0 = 1'b0;
        chk("us100", 64'(od0), 64'(5'b00100));
        chk("us100_sat", 64'(os0), 64'd0);
        tick();
        m0 = 2'b01;
        for (int x = 0; x < 8; x++) begin
            d0 = 3'(x); v0 = 1'b1; tick();
            chk("sweep_valid", 64'(ov0), 64'd1);
        end
        v0 = 1'b0; tick(); tick();

        // Narrowing: signed and unsigned saturation.
        or1 = 1'b1;
        m1 = 2'b10; d1 = {5'b00000, 5'b11110, 5'b10000, 5'b01111}; v1 = 1'b1; tick(); v1 = 1'b0;
        chk("ss_data", 64'(od1), 64'({3'b000, 3'b110, 3'b100, 3'b011}));
        chk("ss_sat", 64'(os1), 64'(4'b0011));
        tick();
        m1 = 2'b11; d1 = {5'b00000, 5'b00000, 5'b01000, 5'b00101}; v1 = 1'b1; tick(); v1 = 1'b0;
        chk("us_data", 64'(od1), 64'({3'b000, 3'b000, 3'b111, 3'b101}));
        chk("us_sat", 64'(os1), 64'(4'b0010));
        tick();

        // Backpressure: 6 beats, output stalled for 4 cycles.
        or1 = 1'b0; v1 = 1'b1; sent = 0; hold = 12'd0;
        for (int i = 0; i < 4; i++) begin
            d1 = 20'($urandom); m1 = 2'($urandom);
            if (ir1) sent++;
            tick();
            if (i == 0) hold = od1;
        end
        chk("bp_rdy", 64'(ir1), 64'd0);
        chk("bp_accepted", 64'(sent), 64'd2);
        chk("bp_hold", 64'(od1), 64'(hold));
        or1 = 1'b1;
        for (int i = 0; i < 40 && sent < 6; i++) begin
            d1 = 20'($urandom); m1 = 2'($urandom);
            if (ir1) sent++;
            tick();
        end
        chk("bp_sent", 64'(sent), 64'd6);
        v1 = 1'b0; tick(); tick(); tick();

        // Saturation counter: saturates at 3, clear wins over increment.
        clr1 = 1'b1; tick(); clr1 = 1'b0;
        chk("cnt_clr", 64'(cnt1), 64'd0);
        m1 = 2'b11; d1 = {4{5'b11111}}; v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("cnt_seq", 64'(cnt1), 64'((i < 3) ? i + 1 : 3));
        end
        clr1 = 1'b1; tick(); clr1 = 1'b0;
        chk("cnt_clr_pri", 64'(cnt1), 64'd0);
        v1 = 1'b0; tick(); tick();

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            v0 = 1'($urandom_range(0, 1)); or0 = ($urandom_range(0, 9) < 7);
            d0 = 3'($urandom); m0 = 2'($urandom); clr0 = ($urandom_range(0, 29) == 0);
            v1 = 1'($urandom_range(0, 1)); or1 = ($urandom_range(0, 9) < 6);
            d1 = 20'($urandom); m1 = 2'($urandom); clr1 = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; clr0 = 1'b0; clr1 = 1'b0;

        // Reset while FULL discards both buffered beats.
        or0 = 1'b0; or1 = 1'b0; v0 = 1'b1; v1 = 1'b1;
        m1 = 2'b10; d1 = {4{5'b01111}};
        for (int i = 0; i < 3; i++) begin
            d0 = 3'($urandom); tick();
        end
        chk("full_rdy0", 64'(ir0), 64'd0);
        chk("full_rdy1", 64'(ir1), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        v0 = 1'b0; v1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
        chk("rst_valid0", 64'(ov0), 64'd0);
        chk("rst_valid1", 64'(ov1), 64'd0);
        chk("rst_cnt1", 64'(cnt1), 64'd0);
        tick();
        chk("rel_rdy0", 64'(ir0), 64'd1);
        chk("rel_rdy1", 64'(ir1), 64'd1);
        tick(); tick();
        chk("no_stale0", 64'(ov0), 64'd0);
        chk("no_stale1", 64'(ov1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
